event_collector: RTL and testbench
==================================

# event_collector

Hardware counterpart of the wait-on-any-event loop in the scheduler tests. It sits between several event producers and a single consumer. The block latches one-cycle event pulses from `N_EVENTS` sources into sticky pending bits and offers them to the consumer one at a time over a valid/ready handshake, choosing among sources round-robin. It emits a `cont_o` pulse each time it is ready for the next event, and counts events lost because their source was already pending.

## Interface
Parameters:
- `N_EVENTS`, default 3: number of event sources, minimum 2.
- `CNT_W`, default 8: width of the drop counter.
- `ID_W`, default `$clog2(N_EVENTS)`: width of the event index.

Ports:
- `clk`  in  1  — the block's single clock; all logic is on its rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `ev_i`  in  N_EVENTS  — event pulses; bit k high for one cycle means one event from source k.
- `cont_o`  out  1  — one-cycle pulse: collector is armed and waiting for an event.
- `evt_valid_o`  out  1  — an event is offered to the consumer.
- `evt_ready_i`  in  1  — consumer accepts the offered event.
- `evt_id_o`  out  ID_W  — source index of the offered event; stable while `evt_valid_o` is high.
- `pending_o`  out  N_EVENTS  — current sticky pending bits.
- `drop_cnt_o`  out  CNT_W  — saturating count of dropped events.

## Operation
- Pending register `pend`, one bit per source.
  - Set when `ev_i[k]` is high.
  - Cleared only on handshake (`evt_valid_o && evt_ready_i`) for `k == evt_id_o`.
  - If a set and a clear of the same bit happen in the same cycle, the set wins. The bit stays 1 and this is not a drop.
- Drop: `ev_i[k]` high while `pend[k]` is already 1 and not being cleared that cycle increments `drop_cnt_o`. The counter saturates at `2^CNT_W-1`. Several drops in one cycle add their count, clamped at saturation.
- FSM states (enum): ARM, WAIT, OFFER.
  - ARM: `cont_o`=1 for exactly this cycle; always go to WAIT.
  - WAIT: if `pend` is nonzero, pick the first set bit searching upward from `rr_ptr` with wrap-around. Register it into `evt_id_o` and go to OFFER. If `pend` is zero, stay in WAIT. The pick uses the registered `pend` only; same-cycle `ev_i` is ignored.
  - OFFER: `evt_valid_o`=1. On `evt_ready_i`, clear the chosen pending bit, set `rr_ptr` to `(evt_id_o+1) mod N_EVENTS`, and go to ARM. Otherwise hold, with `evt_id_o` unchanged.
- Events arriving in any state are captured; nothing is lost except under the drop rule.
- `pending_o` mirrors `pend`.

## Timing
- Reset values: state=ARM, `pend`=0, `rr_ptr`=0, `evt_id_o`=0, `drop_cnt_o`=0, `evt_valid_o`=0, `cont_o`=0 while `rst` is high.
- First cycle after `rst` deasserts: `cont_o`=1.
- `ev_i` sampled in cycle c → `pend` visible in c+1 → `evt_valid_o` high in c+2 at the earliest, when in WAIT at c+1. Minimum latency is 2 cycles.
- Handshake in cycle h → `cont_o` in h+1 → earliest next `evt_valid_o` in h+3, since one event is offered per ARM/WAIT/OFFER round.
- `rst` asserted mid-OFFER drops the offered and all pending events. No handshake completes in a reset cycle.
- The consumer may hold `evt_ready_i` high continuously. The block must not depend on ready-before-valid.

## Structure
- Package `event_pkg` holds the `state_t` enum (ARM, WAIT, OFFER).
- Sub-module `rr_pick`: combinational. Inputs are `req[N_EVENTS]` and `ptr[ID_W]`; outputs are `any` and `idx[ID_W]`. Returns the first set bit at or after `ptr`, wrapping.
- The top level holds `pend`, the FSM, `rr_ptr`, the drop counter, and the output registers.

## Test plan
- Reset release, no events → `cont_o`=1 for one cycle only, then the block stays in WAIT with `evt_valid_o`=0 indefinitely.
- A single pulse on `ev_i`=3'b010 with `evt_ready_i`=1 → `evt_valid_o` 2 cycles later with `evt_id_o`=1. `pend` returns to 0, and `cont_o` pulses the next cycle.
- `ev_i`=3'b111 in one cycle, consumer always ready → ids 0, 1, 2 offered in order, each separated by a `cont_o` pulse; `drop_cnt_o`=0.
- With `rr_ptr`=1, repeated `ev_i`=3'b001 and 3'b100 pending together → order is 2, then 0 (wrap-around fairness).
- Source 0 pulsed 3 times while the consumer holds `evt_ready_i`=0 → one offer with id 0 and `drop_cnt_o`=2. A pulse landing in the same cycle as the handshake re-sets `pend[0]` with no drop. With `CNT_W`=2, `drop_cnt_o` saturates at 3.
- `rst` asserted while in OFFER with `pend`=3'b110 → the next cycle has all outputs at their reset values, then `cont_o`, then nothing is offered until new events arrive.

Source files
------------

// File: rtl/event_collector_pkg.sv
// Shared types for the event collector: the arm/wait/offer handshake states.
package event_pkg;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    WAIT  = 2'd1,
    OFFER = 2'd2
  } state_t;

endpackage

// File: rtl/event_collector_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping past the top.
module rr_pick #(
  parameter int N_EVENTS = 3,
  parameter int ID_W     = $clog2(N_EVENTS)
) (
  input  logic [N_EVENTS-1:0] req,
  input  logic [ID_W-1:0]     ptr,
  output logic                any,
  output logic [ID_W-1:0]     idx
);

  function automatic logic [ID_W-1:0] slot(input logic [ID_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N_EVENTS) s = s - N_EVENTS;
    return ID_W'(s);
  endfunction

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < N_EVENTS; i++) begin
      if (!any && req[slot(ptr, i)]) begin
        any = 1'b1;
        idx = slot(ptr, i);
      end
    end
  end

endmodule

// File: rtl/event_collector.sv
// Latches event pulses into sticky pending bits and hands them to one consumer,
// one per ARM/WAIT/OFFER round, with round-robin source selection.
module event_collector
  import event_pkg::*;
#(
  parameter int N_EVENTS = 3,
  parameter int CNT_W    = 8,
  parameter int ID_W     = $clog2(N_EVENTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_EVENTS-1:0] ev_i,
  output logic                cont_o,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [ID_W-1:0]     evt_id_o,
  output logic [N_EVENTS-1:0] pending_o,
  output logic [CNT_W-1:0]    drop_cnt_o
);

  localparam int PC_W  = ID_W + 1;
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_EVENTS - 1);

  function automatic logic [PC_W-1:0] popcount(input logic [N_EVENTS-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int k = 0; k < N_EVENTS; k++) c = c + PC_W'(v[k]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  state_t              state;
  logic [N_EVENTS-1:0] pend;
  logic [ID_W-1:0]     rr_ptr;
  logic                hs;
  logic [N_EVENTS-1:0] clr;
  logic [N_EVENTS-1:0] drop_vec;
  logic                pick_any;
  logic [ID_W-1:0]     pick_idx;

  assign hs        = evt_valid_o & evt_ready_i;
  assign clr       = hs ? (N_EVENTS'(1) << evt_id_o) : '0;
  // A new pulse on a bit being cleared this cycle re-arms it and is not a drop.
  assign drop_vec  = ev_i & pend & ~clr;
  assign pending_o = pend;

  rr_pick #(
    .N_EVENTS (N_EVENTS),
    .ID_W     (ID_W)
  ) u_pick (
    .req (pend),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARM;
      pend        <= '0;
      rr_ptr      <= '0;
      evt_id_o    <= '0;
      drop_cnt_o  <= '0;
      evt_valid_o <= 1'b0;
      cont_o      <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | ev_i;
      if (|drop_vec) drop_cnt_o <= sat_add(drop_cnt_o, popcount(drop_vec));

      case (state)
        // Coming out of reset ARM is entered with cont_o low; raise it for one cycle.
        ARM: begin
          if (cont_o) begin
            cont_o <= 1'b0;
            state  <= WAIT;
          end else begin
            cont_o <= 1'b1;
          end
        end
        WAIT: begin
          if (pick_any) begin
            evt_id_o    <= pick_idx;
            evt_valid_o <= 1'b1;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready_i) begin
            evt_valid_o <= 1'b0;
            rr_ptr      <= (evt_id_o == LAST_ID) ? '0 : evt_id_o + ID_W'(1);
            cont_o      <= 1'b1;
            state       <= ARM;
          end
        end
        default: state <= ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_event_collector.sv
// Scoreboard bench for event_collector: default instance plus a 2-bit drop counter instance.
module tb_event_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ev, ev2;
  logic       ready, ready2;
  logic       cont, valid, cont2, valid2;
  logic [1:0] id, id2;
  logic [2:0] pend, pend2;
  logic [7:0] drop;
  logic [1:0] drop2;

  int         checks = 0;
  int         passed = 0;
  logic [1:0] exp_q[$];
  logic [1:0] want;
  bit         seen;

  event_collector dut (
    .clk(clk), .rst(rst), .ev_i(ev), .cont_o(cont), .evt_valid_o(valid),
    .evt_ready_i(ready), .evt_id_o(id), .pending_o(pend), .drop_cnt_o(drop)
  );

  event_collector #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .ev_i(ev2), .cont_o(cont2), .evt_valid_o(valid2),
    .evt_ready_i(ready2), .evt_id_o(id2), .pending_o(pend2), .drop_cnt_o(drop2)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; ev = '0; ev2 = '0; ready = 1'b0; ready2 = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_offer(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; ev = '0; ev2 = '0; ready = 1'b0; ready2 = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (cont !== 1'b0) $display("FAIL reset_cont got=%b want=0", cont); else passed++;
    checks++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", valid); else passed++;
    checks++; if (id !== 2'd0) $display("FAIL reset_id got=%0d want=0", id); else passed++;
    checks++; if (pend !== 3'b000) $display("FAIL reset_pend got=%b want=000", pend); else passed++;
    checks++; if (drop !== 8'd0 || drop2 !== 2'd0) $display("FAIL reset_drop got=%0d/%0d want=0/0", drop, drop2); else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cont !== 1'b1) $display("FAIL release_cont got=%b want=1", cont); else passed++;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cont !== 1'b0 || valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL idle_quiet bad_cycles=%0d want=0", bad); else passed++;
  endtask

  task automatic test_single();
    do_reset();
    ready = 1'b1; ev = 3'b010; exp_q.push_back(2'd1);
    @(negedge clk);
    ev = '0;
    checks++; if (pend !== 3'b010) $display("FAIL single_pend got=%b want=010", pend); else passed++;
    checks++; if (valid !== 1'b0) $display("FAIL single_early_valid got=%b want=0", valid); else passed++;
    @(negedge clk);
    checks++; if (valid !== 1'b1) $display("FAIL single_latency valid got=%b want=1", valid); else passed++;
    checks++;
    if (exp_q.size() == 0) $display("FAIL single_sb queue empty");
    else begin
      want = exp_q.pop_front();
      if (id !== want) $display("FAIL single_id got=%0d want=%0d", id, want); else passed++;
    end
    @(negedge clk);
    checks++; if (pend !== 3'b000) $display("FAIL single_clear got=%b want=000", pend); else passed++;
    checks++; if (cont !== 1'b1 || valid !== 1'b0) $display("FAIL single_cont got=%b/%b want=1/0", cont, valid); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready = 1'b1; ev = 3'b111;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    @(negedge clk);
    ev = '0;
    checks++; if (pend !== 3'b111) $display("FAIL b2b_pend got=%b want=111", pend); else passed++;
    for (int k = 0; k < 3; k++) begin
      wait_offer(8, seen);
      checks++;
      if (!seen) $display("FAIL b2b_timeout offer=%0d got=none want=valid", k);
      else if (exp_q.size() == 0) $display("FAIL b2b_sb queue empty");
      else begin
        want = exp_q.pop_front();
        if (id !== want) $display("FAIL b2b_id got=%0d want=%0d", id, want); else passed++;
      end
      @(negedge clk);
      checks++; if (cont !== 1'b1) $display("FAIL b2b_cont offer=%0d got=%b want=1", k, cont); else passed++;
    end
    checks++; if (drop !== 8'd0) $display("FAIL b2b_drop got=%0d want=0", drop); else passed++;
    checks++; if (pend !== 3'b000) $display("FAIL b2b_pend_end got=%b want=000", pend); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    ready = 1'b1; ev = 3'b001; exp_q.push_back(2'd0);
    @(negedge clk);
    ev = '0;
    wait_offer(8, seen);
    checks++;
    if (!seen) $display("FAIL wrap_prime_timeout got=none want=valid");
    else begin
      want = exp_q.pop_front();
      if (id !== want) $display("FAIL wrap_prime_id got=%0d want=%0d", id, want); else passed++;
    end
    @(negedge clk);
    ev = 3'b101; exp_q.push_back(2'd2); exp_q.push_back(2'd0);
    @(negedge clk);
    ev = '0;
    checks++; if (pend !== 3'b101) $display("FAIL wrap_pend got=%b want=101", pend); else passed++;
    for (int k = 0; k < 2; k++) begin
      wait_offer(8, seen);
      checks++;
      if (!seen) $display("FAIL wrap_timeout offer=%0d got=none want=valid", k);
      else if (exp_q.size() == 0) $display("FAIL wrap_sb queue empty");
      else begin
        want = exp_q.pop_front();
        if (id !== want) $display("FAIL wrap_order offer=%0d got=%0d want=%0d", k, id, want); else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_drop();
    int bad;
    do_reset();
    ready = 1'b0; ev = 3'b001; exp_q.push_back(2'd0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    ev = '0;
    checks++; if (drop !== 8'd2) $display("FAIL drop_count got=%0d want=2", drop); else passed++;
    checks++; if (valid !== 1'b1) $display("FAIL drop_valid got=%b want=1", valid); else passed++;
    checks++;
    if (exp_q.size() == 0) $display("FAIL drop_sb queue empty");
    else begin
      want = exp_q.pop_front();
      if (id !== want) $display("FAIL drop_id got=%0d want=%0d", id, want); else passed++;
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid !== 1'b1 || id !== 2'd0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL drop_hold bad_cycles=%0d want=0", bad); else passed++;
    ready = 1'b1; ev = 3'b001; exp_q.push_back(2'd0);
    @(negedge clk);
    ev = '0;
    checks++; if (pend !== 3'b001) $display("FAIL drop_setwins got=%b want=001", pend); else passed++;
    checks++; if (drop !== 8'd2) $display("FAIL drop_setwins_cnt got=%0d want=2", drop); else passed++;
    checks++; if (cont !== 1'b1) $display("FAIL drop_hs_cont got=%b want=1", cont); else passed++;
    wait_offer(8, seen);
    checks++;
    if (!seen) $display("FAIL drop_reoffer_timeout got=none want=valid");
    else if (exp_q.size() == 0) $display("FAIL drop_sb2 queue empty");
    else begin
      want = exp_q.pop_front();
      if (id !== want) $display("FAIL drop_reoffer_id got=%0d want=%0d", id, want); else passed++;
    end
    @(negedge clk);
    checks++; if (pend !== 3'b000) $display("FAIL drop_final_pend got=%b want=000", pend); else passed++;
    ready = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    ready2 = 1'b0; ev2 = 3'b001;
    @(negedge clk); @(negedge clk);
    checks++; if (drop2 !== 2'd1) $display("FAIL sat_step1 got=%0d want=1", drop2); else passed++;
    ev2 = 3'b111;
    @(negedge clk);
    checks++; if (drop2 !== 2'd2) $display("FAIL sat_step2 got=%0d want=2", drop2); else passed++;
    @(negedge clk);
    checks++; if (drop2 !== 2'd3) $display("FAIL sat_clamp got=%0d want=3", drop2); else passed++;
    ev2 = 3'b001;
    @(negedge clk);
    ev2 = '0;
    checks++; if (drop2 !== 2'd3) $display("FAIL sat_hold got=%0d want=3", drop2); else passed++;
    checks++; if (drop !== 8'd0) $display("FAIL sat_other_inst got=%0d want=0", drop); else passed++;
  endtask

  task automatic test_rst_offer();
    int bad;
    do_reset();
    ready = 1'b0; ev = 3'b110;
    @(negedge clk);
    ev = '0;
    @(negedge clk);
    checks++; if (valid !== 1'b1 || id !== 2'd1) $display("FAIL rst_pre_offer got=%b/%0d want=1/1", valid, id); else passed++;
    checks++; if (pend !== 3'b110) $display("FAIL rst_pre_pend got=%b want=110", pend); else passed++;
    rst = 1'b1; ready = 1'b1;
    @(negedge clk);
    checks++;
    if (cont !== 1'b0 || valid !== 1'b0 || id !== 2'd0 || pend !== 3'b000 || drop !== 8'd0)
      $display("FAIL rst_mid_offer got=c%b v%b id%0d p%b d%0d want=c0 v0 id0 p000 d0", cont, valid, id, pend, drop);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cont !== 1'b1) $display("FAIL rst_cont got=%b want=1", cont); else passed++;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid !== 1'b0 || cont !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL rst_no_offer bad_cycles=%0d want=0", bad); else passed++;
    ev = 3'b100; exp_q.push_back(2'd2);
    @(negedge clk);
    ev = '0;
    wait_offer(8, seen);
    checks++;
    if (!seen) $display("FAIL rst_new_timeout got=none want=valid");
    else if (exp_q.size() == 0) $display("FAIL rst_sb queue empty");
    else begin
      want = exp_q.pop_front();
      if (id !== want) $display("FAIL rst_new_id got=%0d want=%0d", id, want); else passed++;
    end
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_drop();
    test_saturate();
    test_rst_offer();
    checks++; if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d want=0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
